// File: rtl/router_fifo_pkt_if.sv
// Router output FIFO bus: write side, read side
// and status, grouped for the packet-aware FIFO.
interface router_fifo_pkt_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                  soft_reset;
  logic                  write_enb;
  logic                  lfd_state;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_enb;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [AW:0]           count;
  logic [DATA_WIDTH-2:0] pkt_remaining;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output soft_reset,
    output write_enb,
    output lfd_state,
    output data_in,
    output read_enb,
    input  data_out,
    input  full,
    input  empty,
    input  almost_full,
    input  count,
    input  pkt_remaining,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  soft_reset,
    input  write_enb,
    input  lfd_state,
    input  data_in,
    input  read_enb,
    output data_out,
    output full,
    output empty,
    output almost_full,
    output count,
    output pkt_remaining,
    output overflow,
    output underflow
  );
endinterface

// File: rtl/router_fifo_pkt.sv
// Packet-aware router output FIFO: tagged words,
// remaining-word counter, occupancy and sticky errors.
module router_fifo_pkt #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2
) (
  input  logic              clock,
  input  logic              resetn,
  router_fifo_pkt_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = DATA_WIDTH - 1;

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_AF   = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] CNT_ZERO = '0;
  localparam logic [AW:0] ONE      = (AW+1)'(1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [PW-1:0] P_ZERO = '0;

  logic [DATA_WIDTH:0]   r_mem [DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [AW:0]           r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [PW-1:0]         r_pkt;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr;
  logic                  w_rd;
  logic [DATA_WIDTH:0]   w_rd_word;
  logic [PW-1:0]         w_hdr_len;
  logic [PW-1:0]         w_pkt_nxt;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == CNT_ZERO);

  // A flush wins over both ports; full/empty
  // gate on the count held at the cycle start.
  assign w_wr = bus.write_enb & ~w_full
              & ~bus.soft_reset;
  assign w_rd = bus.read_enb & ~w_empty
              & ~bus.soft_reset;

  assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];

  // Header length plus one for the parity word.
  assign w_hdr_len =
    {1'b0, w_rd_word[DATA_WIDTH-1:2]} + P_ONE;

  // Next remaining-word count for an accepted read.
  always_comb begin
    w_pkt_nxt = r_pkt;
    unique case (1'b1)
      w_rd_word[DATA_WIDTH]: w_pkt_nxt = w_hdr_len;
      (r_pkt != P_ZERO):     w_pkt_nxt = r_pkt - P_ONE;
      default:               w_pkt_nxt = r_pkt;
    endcase
  end

  // Storage array; contents survive both resets.
  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <=
        {bus.lfd_state, bus.data_in};
    end
  end

  // Pointers, occupancy, read data and packet count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_pkt      <= '0;
    end else if (bus.soft_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_pkt      <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ONE;
      end
      if (w_rd) begin
        r_rd_ptr   <= r_rd_ptr + ONE;
        r_data_out <= w_rd_word[DATA_WIDTH-1:0];
        r_pkt      <= w_pkt_nxt;
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + ONE;
        2'b01:   r_count <= r_count - ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags for rejected requests.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (bus.soft_reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (bus.write_enb && w_full) begin
        r_ovf <= 1'b1;
      end
      if (bus.read_enb && w_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign bus.data_out      = r_data_out;
  assign bus.full          = w_full;
  assign bus.empty         = w_empty;
  assign bus.almost_full   = (r_count >= CNT_AF);
  assign bus.count         = r_count;
  assign bus.pkt_remaining = r_pkt;
  assign bus.overflow      = r_ovf;
  assign bus.underflow     = r_udf;
endmodule

// File: tb/tb_router_fifo_pkt.sv
// Self-checking bench for router_fifo_pkt with a
// queue scoreboard of tagged words.
module tb_router_fifo_pkt;
  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  router_fifo_pkt_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

  router_fifo_pkt #(
    .DATA_WIDTH(8),
    .DEPTH(16),
    .AF_THRESH(14)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] q [$];
  logic [7:0] m_dout;
  logic [6:0] m_pkt;
  logic       m_ovf;
  logic       m_udf;

  task automatic model_clear();
    q.delete();
    m_dout = 8'h00;
    m_pkt  = 7'd0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // Drive one cycle and advance the scoreboard.
  task automatic cyc(input logic w, input logic lfd,
                     input logic [7:0] d,
                     input logic r, input logic sr);
    logic [8:0] e;
    bit fl;
    bit em;
    fl = (q.size() == 16);
    em = (q.size() == 0);
    if (sr) begin
      model_clear();
    end else begin
      if (r && !em) begin
        e = q.pop_front();
        m_dout = e[7:0];
        if (e[8]) m_pkt = {1'b0, e[7:2]} + 7'd1;
        else if (m_pkt != 7'd0) m_pkt = m_pkt - 7'd1;
      end
      if (w && !fl) q.push_back({lfd, d});
      if (w && fl) m_ovf = 1'b1;
      if (r && em) m_udf = 1'b1;
    end
    bus.write_enb  = w;
    bus.lfd_state  = lfd;
    bus.data_in    = d;
    bus.read_enb   = r;
    bus.soft_reset = sr;
    @(posedge clock);
    #1;
    bus.write_enb  = 1'b0;
    bus.lfd_state  = 1'b0;
    bus.data_in    = 8'h00;
    bus.read_enb   = 1'b0;
    bus.soft_reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (bus.count !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_count: got %0d expected 0", bus.count);
    end
    n_checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags: got e%b f%b af%b expected e1 f0 af0",
               bus.empty, bus.full, bus.almost_full);
    end
    n_checks++;
    if (bus.data_out !== 8'h00 || bus.pkt_remaining !== 7'd0) begin
      n_fail++;
      $display("FAIL rst_data: got %0h/%0d expected 0/0",
               bus.data_out, bus.pkt_remaining);
    end
    n_checks++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_err: got %b%b expected 00",
               bus.overflow, bus.underflow);
    end
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_packet();
    logic [7:0] exp_d [6] = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24, 8'hA5};
    logic [6:0] exp_p [6] = '{7'd5, 7'd4, 7'd3, 7'd2, 7'd1, 7'd0};
    for (int i = 0; i < 6; i++) cyc(1'b1, i == 0, exp_d[i], 1'b0, 1'b0);
    n_checks++;
    if (bus.count !== 5'd6) begin
      n_fail++;
      $display("FAIL pkt_count: got %0d expected 6", bus.count);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (bus.data_out !== exp_d[i] || bus.data_out !== m_dout) begin
        n_fail++;
        $display("FAIL pkt_data[%0d]: got %0h expected %0h", i, bus.data_out, exp_d[i]);
      end
      n_checks++;
      if (bus.pkt_remaining !== exp_p[i]) begin
        n_fail++;
        $display("FAIL pkt_rem[%0d]: got %0d expected %0d", i, bus.pkt_remaining, exp_p[i]);
      end
    end
    n_checks++;
    if (bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL pkt_empty: got %b expected 1", bus.empty);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
      n_checks++;
      if (bus.count !== 5'(i + 1) ||
          bus.almost_full !== (i + 1 >= 14) ||
          bus.full !== (i == 15)) begin
        n_fail++;
        $display("FAIL fill[%0d]: got c%0d af%b f%b expected c%0d af%b f%b",
                 i, bus.count, bus.almost_full, bus.full,
                 i + 1, i + 1 >= 14, i == 15);
      end
    end
    cyc(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
      n_fail++;
      $display("FAIL fill_ovf: got o%b c%0d expected o1 c16", bus.overflow, bus.count);
    end
    cyc(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
    n_checks++;
    if (bus.count !== 5'd15 || bus.data_out !== 8'h40) begin
      n_fail++;
      $display("FAIL full_rw: got c%0d d%0h expected c15 d40", bus.count, bus.data_out);
    end
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (bus.data_out !== 8'(8'h41 + i)) begin
        n_fail++;
        $display("FAIL fill_drain[%0d]: got %0h expected %0h", i, bus.data_out, 8'(8'h41 + i));
      end
    end
    n_checks++;
    if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_end: got e%b o%b expected e1 o1", bus.empty, bus.overflow);
    end
  endtask

  task automatic test_simultaneous();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_clr: got %b expected 0", bus.overflow);
    end
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h70 + i), 1'b1, 1'b0);
      n_checks++;
      if (bus.count !== 5'd5 || bus.data_out !== 8'(8'h60 + i)) begin
        n_fail++;
        $display("FAIL sim_rw[%0d]: got c%0d d%0h expected c5 d%0h",
                 i, bus.count, bus.data_out, 8'(8'h60 + i));
      end
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (bus.data_out !== m_dout || bus.count !== 5'(4 - i)) begin
        n_fail++;
        $display("FAIL sim_drain[%0d]: got d%0h c%0d expected d%0h c%0d",
                 i, bus.data_out, bus.count, m_dout, 4 - i);
      end
    end
  endtask

  task automatic test_underflow_wrap();
    logic [7:0] d;
    int bad;
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (bus.underflow !== 1'b1 || bus.data_out !== 8'h77) begin
      n_fail++;
      $display("FAIL udf: got u%b d%0h expected u1 d77", bus.underflow, bus.data_out);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      cyc(1'b1, 1'b0, d, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      if (bus.data_out !== d) begin
        bad++;
        $display("FAIL wrap[%0d]: got %0h expected %0h", i, bus.data_out, d);
      end
    end
    n_checks++;
    if (bad != 0) n_fail++;
    n_checks++;
    if (bus.empty !== 1'b1 || bus.underflow !== m_udf) begin
      n_fail++;
      $display("FAIL wrap_end: got e%b u%b expected e1 u%b", bus.empty, bus.underflow, m_udf);
    end
  endtask

  task automatic test_soft_reset();
    logic [7:0] pk [6] = '{8'h11, 8'h31, 8'h32, 8'h33, 8'h34, 8'h5C};
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, i == 0, pk[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (bus.pkt_remaining !== 7'd3 || bus.data_out !== 8'h32) begin
      n_fail++;
      $display("FAIL sr_mid: got p%0d d%0h expected p3 d32", bus.pkt_remaining, bus.data_out);
    end
    cyc(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1);
    n_checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.pkt_remaining !== 7'd0) begin
      n_fail++;
      $display("FAIL sr_cnt: got c%0d e%b p%0d expected c0 e1 p0",
               bus.count, bus.empty, bus.pkt_remaining);
    end
    n_checks++;
    if (bus.data_out !== 8'h00 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL sr_clr: got d%0h o%b u%b expected d0 o0 u0",
               bus.data_out, bus.overflow, bus.underflow);
    end
    cyc(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (bus.data_out !== 8'h5A || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL sr_after: got d%0h e%b expected d5a e1", bus.data_out, bus.empty);
    end
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 1'b1, 8'h09, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h13, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h14, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (bus.pkt_remaining !== m_pkt || bus.data_out !== 8'h13) begin
      n_fail++;
      $display("FAIL ar_pre: got p%0d d%0h expected p%0d d13",
               bus.pkt_remaining, bus.data_out, m_pkt);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
        bus.almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_flags: got c%0d e%b f%b af%b expected c0 e1 f0 af0",
               bus.count, bus.empty, bus.full, bus.almost_full);
    end
    n_checks++;
    if (bus.data_out !== 8'h00 || bus.pkt_remaining !== 7'd0 ||
        bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_data: got d%0h p%0d o%b u%b expected 0",
               bus.data_out, bus.pkt_remaining, bus.overflow, bus.underflow);
    end
    bus.write_enb = 1'b1;
    bus.data_in   = 8'hAB;
    @(posedge clock);
    #1;
    bus.write_enb = 1'b0;
    n_checks++;
    if (bus.count !== 5'd0) begin
      n_fail++;
      $display("FAIL ar_hold: got c%0d expected 0", bus.count);
    end
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    model_clear();
    cyc(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (bus.data_out !== 8'h3C || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_after: got d%0h e%b expected d3c e1", bus.data_out, bus.empty);
    end
  endtask

  initial begin
    resetn         = 1'b0;
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b0;
    bus.lfd_state  = 1'b0;
    bus.data_in    = 8'h00;
    bus.read_enb   = 1'b0;
    model_clear();
    test_reset();
    test_packet();
    test_fill();
    test_simultaneous();
    test_underflow_wrap();
    test_soft_reset();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/router_fifo_pkt.md
# router_fifo_pkt

Parametrised, packet-aware successor to the router output FIFO. It sits between the router synchroniser/FSM write side and one destination port's read side. It buffers DATA_WIDTH-bit words and tags each word with the header flag (lfd_state) at write time. A read-side packet counter is loaded from the header length field, so the block reports how many words of the current packet remain. It adds an occupancy count, an almost-full flag, sticky overflow/underflow errors and a synchronous flush.

## Interface
- DATA_WIDTH, 8: payload word width; header word = {payload_len[DATA_WIDTH-1:2], addr[1:0]}.
- DEPTH, 16: number of entries; power of two, ≥ 4.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH; range 1..DEPTH.
- Derived: AW = log2(DEPTH).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- soft_reset  in  1  synchronous flush, active-high.
- write_enb  in  1  write request.
- lfd_state  in  1  marks data_in as a header word; stored as the tag bit.
- data_in  in  DATA_WIDTH  write data.
- read_enb  in  1  read request.
- data_out  out  DATA_WIDTH  registered read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- count  out  AW+1  occupancy, 0..DEPTH.
- pkt_remaining  out  DATA_WIDTH-1  words of the current packet still to be read after the last read.
- overflow  out  1  sticky; set by write_enb while full.
- underflow  out  1  sticky; set by read_enb while empty.

## Operation
- Storage: DEPTH × (DATA_WIDTH+1) memory, holding {tag, data}. Write and read pointers are AW+1 bits and wrap naturally modulo 2·DEPTH.
- Write accepted: write_enb && !full. mem[wr_ptr] ← {lfd_state, data_in}; wr_ptr increments.
- Read accepted: read_enb && !empty. data_out ← mem[rd_ptr].data; rd_ptr increments.
- full and empty reflect the registered count at the start of the cycle.
  - When full, a write is rejected even if a read is accepted in the same cycle.
  - When empty, a read is rejected even if a write is accepted in the same cycle.
- count update per cycle: +1 if write only, −1 if read only, unchanged if both or neither.
- Packet counter, on an accepted read:
  - Tag = 1 (header): pkt_remaining ← header[DATA_WIDTH-1:2] + 1 (payload words plus parity).
  - Tag = 0 and pkt_remaining ≠ 0: pkt_remaining decrements.
  - Tag = 0 and pkt_remaining = 0: pkt_remaining stays 0 (stray word; no error).
- Packet counter with no accepted read: pkt_remaining holds.
- A header with length 0 loads 1 (parity only).
- data_out holds its value when no read is accepted.
- overflow/underflow are set on a rejected request and stay set until resetn or soft_reset.
- soft_reset (synchronous): clears pointers, count, pkt_remaining, data_out, overflow and underflow. It overrides any read or write in the same cycle; memory contents are not cleared.
- resetn low (asynchronous, any time including mid-packet):
  - Outputs immediately go to: data_out=0, count=0, empty=1, full=0, almost_full=0, pkt_remaining=0, overflow=0, underflow=0.
  - Memory contents are don't-care.

## Timing
- Write at edge N: count/empty/full/almost_full reflect it after edge N. The earliest read of that word is at edge N+1.
- Read latency: data_out is valid immediately after the edge that accepts the read, and is sampled by the consumer one cycle later.
- pkt_remaining updates on the same edge as the data_out it describes.
- full asserts after the DEPTH-th write with no reads; empty asserts after the last read.
- Simultaneous read+write at 0 < count < DEPTH: both accepted, count unchanged, pointers both advance.
- Deassertion of resetn is taken synchronously at the next rising edge; no operation occurs on that edge if resetn is still low.

## Test plan
- Reset: hold resetn=0 mid-run → all outputs at the reset values listed above, immediately without waiting for a clock edge; empty=1, count=0.
- Packet (DATA_WIDTH=8): write header 0x11 (len 4, addr 01) with lfd_state=1, then 4 payload words and parity 0xA5; read all 6 → pkt_remaining sequence 5,4,3,2,1,0; data_out matches write order; empty=1 after the 6th read.
- Fill (DEPTH=16, AF_THRESH=14): 16 writes → almost_full at count 14, full at 16. A 17th write is rejected: overflow=1, count=16, contents unchanged.
- Simultaneous: at count=5, assert read_enb and write_enb for 3 cycles → count stays 5 and FIFO ordering is preserved. At count=16 with both asserted → count 15, write dropped, overflow=1.
- Underflow and wrap: read while empty → underflow=1, data_out unchanged. Then 40 write/read pairs → data integrity is kept across pointer wrap.
- soft_reset mid-packet: after reading header plus 2 words (pkt_remaining=3), pulse soft_reset with write_enb=1 → count=0, pkt_remaining=0, data_out=0, flags cleared, and the concurrent write is not stored.
